// File: rtl/rht_recovery_ctrl.sv
// Misprediction recovery sequencer: walks the RHT newest-to-oldest, restoring
// RAT mappings and freeing squashed pregs, then rewinds the RHT tail.
module rht_recovery_ctrl #(
    parameter int P_REGISTERS = 64,
    parameter int L_REGISTERS = 32,
    parameter int C_NUM       = 4,
    parameter int K           = 32,
    localparam int PW         = $clog2(P_REGISTERS),
    localparam int LW         = $clog2(L_REGISTERS),
    localparam int RHT_DEPTH  = C_NUM * K,
    localparam int RW         = $clog2(RHT_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_valid,
    input  logic [RW-1:0] flush_rht_id,
    input  logic [RW-1:0] rht_tail,
    input  logic [RW:0]   rht_count,
    input  logic          pause,
    output logic          flush_ack,
    output logic          flush_err,
    output logic          rd_en,
    output logic [RW-1:0] rd_id,
    input  logic [LW-1:0] rd_lreg,
    input  logic [PW-1:0] rd_preg,
    input  logic [PW-1:0] rd_ppreg,
    input  logic          rd_valid_entry,
    output logic          restore_en,
    output logic [LW-1:0] restore_lreg,
    output logic [PW-1:0] restore_preg,
    output logic          free_en,
    output logic [PW-1:0] free_preg,
    output logic          rec_busy,
    output logic          tail_wr_en,
    output logic [RW-1:0] new_tail,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, WALK, DRAIN, DONE} state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] cur_p0, cur_nxt;
    logic [RW-1:0] rem_p0, rem_nxt;
    logic [RW-1:0] target_p0, target_nxt;
    logic [RW-1:0] cnt;
    logic          vld_p1;

    // Entries to undo; a full RHT is indistinguishable from empty here.
    assign cnt = rht_tail - flush_rht_id;

    always_comb begin
        state_nxt  = state;
        cur_nxt    = cur_p0;
        rem_nxt    = rem_p0;
        target_nxt = target_p0;
        flush_ack  = 1'b0;
        flush_err  = 1'b0;
        rd_en      = 1'b0;
        rd_id      = '0;
        tail_wr_en = 1'b0;
        new_tail   = '0;
        done       = 1'b0;
        rec_busy   = (state != IDLE);
        case (state)
            IDLE: begin
                if (flush_valid && !rst) begin
                    if ({1'b0, cnt} <= rht_count) begin
                        flush_ack  = 1'b1;
                        cur_nxt    = rht_tail - RW'(1);
                        rem_nxt    = cnt;
                        target_nxt = flush_rht_id;
                        state_nxt  = (cnt != '0) ? WALK : DONE;
                    end else begin
                        flush_err = 1'b1;
                    end
                end
            end
            WALK: begin
                if (!pause) begin
                    rd_en   = 1'b1;
                    rd_id   = cur_p0;
                    cur_nxt = cur_p0 - RW'(1);
                    rem_nxt = rem_p0 - RW'(1);
                    if (rem_p0 == RW'(1)) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_nxt = DONE;
            end
            DONE: begin
                tail_wr_en = 1'b1;
                new_tail   = target_p0;
                done       = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            vld_p1 <= 1'b0;
        end else begin
            state  <= state_nxt;
            vld_p1 <= rd_en;
        end
    end

    // Walk pointers only matter once latched from IDLE, so they carry no reset.
    always_ff @(posedge clk) begin
        cur_p0    <= cur_nxt;
        rem_p0    <= rem_nxt;
        target_p0 <= target_nxt;
    end

    // ---- p1: RHT read data returns; apply it to RAT and free list ----
    always_comb begin
        restore_en   = vld_p1 & rd_valid_entry;
        free_en      = restore_en;
        restore_lreg = restore_en ? rd_lreg  : '0;
        restore_preg = restore_en ? rd_ppreg : '0;
        free_preg    = restore_en ? rd_preg  : '0;
    end

endmodule

// File: tb/tb_rht_recovery_ctrl.sv
// Directed bench for rht_recovery_ctrl with a one-cycle-latency RHT memory model.
module tb_rht_recovery_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush_valid = 1'b0;
    logic [6:0] flush_rht_id = '0;
    logic [6:0] rht_tail = '0;
    logic [7:0] rht_count = '0;
    logic       pause = 1'b0;
    logic       flush_ack, flush_err, rd_en;
    logic [6:0] rd_id;
    logic [4:0] rd_lreg = '0;
    logic [5:0] rd_preg = '0;
    logic [5:0] rd_ppreg = '0;
    logic       rd_valid_entry = 1'b0;
    logic       restore_en, free_en, rec_busy, tail_wr_en, done;
    logic [4:0] restore_lreg;
    logic [5:0] restore_preg, free_preg;
    logic [6:0] new_tail;

    int checks = 0;
    int errors = 0;

    rht_recovery_ctrl dut (
        .clk(clk), .rst(rst), .flush_valid(flush_valid), .flush_rht_id(flush_rht_id),
        .rht_tail(rht_tail), .rht_count(rht_count), .pause(pause),
        .flush_ack(flush_ack), .flush_err(flush_err), .rd_en(rd_en), .rd_id(rd_id),
        .rd_lreg(rd_lreg), .rd_preg(rd_preg), .rd_ppreg(rd_ppreg),
        .rd_valid_entry(rd_valid_entry), .restore_en(restore_en),
        .restore_lreg(restore_lreg), .restore_preg(restore_preg), .free_en(free_en),
        .free_preg(free_preg), .rec_busy(rec_busy), .tail_wr_en(tail_wr_en),
        .new_tail(new_tail), .done(done)
    );

    always #5 clk = ~clk;

    // RHT contents: fixed functions of the entry index; entry 40 is invalid.
    function automatic logic [4:0] f_lreg(int i);
        return 5'(i % 32);
    endfunction
    function automatic logic [5:0] f_preg(int i);
        return 6'((i + 17) % 64);
    endfunction
    function automatic logic [5:0] f_ppreg(int i);
        return 6'((i + 40) % 64);
    endfunction

    always @(posedge clk) begin
        if (rd_en) begin
            rd_lreg        <= f_lreg(int'(rd_id));
            rd_preg        <= f_preg(int'(rd_id));
            rd_ppreg       <= f_ppreg(int'(rd_id));
            rd_valid_entry <= (rd_id != 7'd40);
        end
    end

    function automatic logic [42:0] all_outs();
        return {flush_ack, flush_err, rd_en, rd_id, restore_en, restore_lreg, restore_preg,
                free_en, free_preg, rec_busy, tail_wr_en, new_tail, done};
    endfunction

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            rst = (c < 2);
            @(negedge clk);
            checks++;
            if (all_outs() !== 43'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d got %h want 0", c, all_outs());
            end
        end
    endtask

    task automatic test_basic_walk();
        logic [7:0]  exp_rd;
        logic [18:0] exp_rs;
        logic [8:0]  exp_dn;
        int rid;
        @(posedge clk); #1;
        flush_valid = 1'b1; rht_tail = 7'd10; rht_count = 8'd10; flush_rht_id = 7'd7;
        @(negedge clk);
        checks++;
        if ({flush_ack, flush_err, rec_busy} !== 3'b100) begin
            errors++;
            $display("FAIL basic_ack got %b want 100", {flush_ack, flush_err, rec_busy});
        end
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            flush_valid = 1'b0;
            @(negedge clk);
            rid    = 11 - c;
            exp_rd = (c <= 3) ? {1'b1, 7'(10 - c)} : 8'd0;
            exp_rs = (c >= 2 && c <= 4) ? {1'b1, f_lreg(rid), f_ppreg(rid), 1'b1, f_preg(rid)} : 19'd0;
            exp_dn = (c == 5) ? {1'b1, 1'b1, 7'd7} : 9'd0;
            checks += 4;
            if ({rd_en, rd_id} !== exp_rd) begin
                errors++;
                $display("FAIL basic_read cycle %0d got %h want %h", c, {rd_en, rd_id}, exp_rd);
            end
            if ({restore_en, restore_lreg, restore_preg, free_en, free_preg} !== exp_rs) begin
                errors++;
                $display("FAIL basic_restore cycle %0d got %h want %h", c,
                         {restore_en, restore_lreg, restore_preg, free_en, free_preg}, exp_rs);
            end
            if ({done, tail_wr_en, new_tail} !== exp_dn) begin
                errors++;
                $display("FAIL basic_done cycle %0d got %h want %h", c, {done, tail_wr_en, new_tail}, exp_dn);
            end
            if (rec_busy !== (c <= 5)) begin
                errors++;
                $display("FAIL basic_busy cycle %0d got %b want %b", c, rec_busy, (c <= 5));
            end
        end
    endtask

    task automatic test_wrap_and_zero();
        int rds[8] = '{-1, 1, 0, 127, 126, -1, -1, -1};
        logic [7:0]  exp_rd;
        logic [18:0] exp_rs;
        logic [8:0]  exp_dn;
        int rid;
        @(posedge clk); #1;
        flush_valid = 1'b1; rht_tail = 7'd2; rht_count = 8'd20; flush_rht_id = 7'd126;
        @(negedge clk);
        checks++;
        if ({flush_ack, flush_err} !== 2'b10) begin
            errors++;
            $display("FAIL wrap_ack got %b want 10", {flush_ack, flush_err});
        end
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            flush_valid = 1'b0;
            @(negedge clk);
            rid    = rds[c - 1];
            exp_rd = (rds[c] >= 0) ? {1'b1, 7'(rds[c])} : 8'd0;
            exp_rs = (rid >= 0) ? {1'b1, f_lreg(rid), f_ppreg(rid), 1'b1, f_preg(rid)} : 19'd0;
            exp_dn = (c == 6) ? {1'b1, 1'b1, 7'd126} : 9'd0;
            checks += 3;
            if ({rd_en, rd_id} !== exp_rd) begin
                errors++;
                $display("FAIL wrap_read cycle %0d got %h want %h", c, {rd_en, rd_id}, exp_rd);
            end
            if ({restore_en, restore_lreg, restore_preg, free_en, free_preg} !== exp_rs) begin
                errors++;
                $display("FAIL wrap_restore cycle %0d got %h want %h", c,
                         {restore_en, restore_lreg, restore_preg, free_en, free_preg}, exp_rs);
            end
            if ({done, tail_wr_en, new_tail} !== exp_dn) begin
                errors++;
                $display("FAIL wrap_done cycle %0d got %h want %h", c, {done, tail_wr_en, new_tail}, exp_dn);
            end
        end
        // Zero-length flush: straight to DONE.
        @(posedge clk); #1;
        flush_valid = 1'b1; rht_tail = 7'd126; rht_count = 8'd5; flush_rht_id = 7'd126;
        @(negedge clk);
        checks++;
        if ({flush_ack, flush_err} !== 2'b10) begin
            errors++;
            $display("FAIL zero_ack got %b want 10", {flush_ack, flush_err});
        end
        @(posedge clk); #1;
        flush_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({rd_en, rec_busy, done, tail_wr_en, new_tail} !== {4'b0111, 7'd126}) begin
            errors++;
            $display("FAIL zero_done got %h want %h", {rd_en, rec_busy, done, tail_wr_en, new_tail},
                     {4'b0111, 7'd126});
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({rec_busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL zero_idle got %b want 00", {rec_busy, done});
        end
    endtask

    task automatic test_illegal();
        @(posedge clk); #1;
        flush_valid = 1'b1; rht_tail = 7'd5; rht_count = 8'd3; flush_rht_id = 7'd0;
        @(negedge clk);
        checks++;
        if ({flush_ack, flush_err, rec_busy} !== 3'b010) begin
            errors++;
            $display("FAIL illegal_err got %b want 010", {flush_ack, flush_err, rec_busy});
        end
        @(posedge clk); #1;
        flush_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({rec_busy, rd_en, done} !== 3'b000) begin
            errors++;
            $display("FAIL illegal_idle got %b want 000", {rec_busy, rd_en, done});
        end
    endtask

    task automatic test_pause_invalid();
        int rds[10] = '{-1, 41, -1, -1, 40, 39, -1, -1, -1, -1};
        logic [7:0]  exp_rd;
        logic [18:0] exp_rs;
        logic [8:0]  exp_dn;
        int rid;
        @(posedge clk); #1;
        flush_valid = 1'b1; rht_tail = 7'd42; rht_count = 8'd42; flush_rht_id = 7'd39;
        @(negedge clk);
        checks++;
        if (flush_ack !== 1'b1) begin
            errors++;
            $display("FAIL pause_ack got %b want 1", flush_ack);
        end
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            flush_valid = 1'b0;
            pause = (c == 2 || c == 3);
            @(negedge clk);
            rid    = rds[c - 1];
            exp_rd = (rds[c] >= 0) ? {1'b1, 7'(rds[c])} : 8'd0;
            exp_rs = (rid >= 0 && rid != 40) ?
                     {1'b1, f_lreg(rid), f_ppreg(rid), 1'b1, f_preg(rid)} : 19'd0;
            exp_dn = (c == 7) ? {1'b1, 1'b1, 7'd39} : 9'd0;
            checks += 4;
            if ({rd_en, rd_id} !== exp_rd) begin
                errors++;
                $display("FAIL pause_read cycle %0d got %h want %h", c, {rd_en, rd_id}, exp_rd);
            end
            if ({restore_en, restore_lreg, restore_preg, free_en, free_preg} !== exp_rs) begin
                errors++;
                $display("FAIL pause_restore cycle %0d got %h want %h", c,
                         {restore_en, restore_lreg, restore_preg, free_en, free_preg}, exp_rs);
            end
            if ({done, tail_wr_en, new_tail} !== exp_dn) begin
                errors++;
                $display("FAIL pause_done cycle %0d got %h want %h", c, {done, tail_wr_en, new_tail}, exp_dn);
            end
            if (rec_busy !== (c <= 7)) begin
                errors++;
                $display("FAIL pause_busy cycle %0d got %b want %b", c, rec_busy, (c <= 7));
            end
        end
        pause = 1'b0;
    endtask

    task automatic test_collisions();
        @(posedge clk); #1;
        flush_valid = 1'b1; rht_tail = 7'd50; rht_count = 8'd50; flush_rht_id = 7'd45;
        @(negedge clk);
        checks++;
        if (flush_ack !== 1'b1) begin
            errors++;
            $display("FAIL coll_ack got %b want 1", flush_ack);
        end
        // A flush that would be legal in IDLE must be ignored mid-walk.
        @(posedge clk); #1;
        flush_rht_id = 7'd0;
        @(negedge clk);
        checks++;
        if ({flush_ack, flush_err, rd_en, rd_id, rec_busy} !== {3'b001, 7'd49, 1'b1}) begin
            errors++;
            $display("FAIL coll_ignore got %h want %h", {flush_ack, flush_err, rd_en, rd_id, rec_busy},
                     {3'b001, 7'd49, 1'b1});
        end
        @(posedge clk); #1;
        flush_valid = 1'b0;
        rst = 1'b1;
        for (int c = 3; c <= 4; c++) begin
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            checks++;
            if (all_outs() !== 43'd0) begin
                errors++;
                $display("FAIL coll_reset cycle %0d got %h want 0", c, all_outs());
            end
        end
        @(posedge clk); #1;
        flush_valid = 1'b1; flush_rht_id = 7'd49;
        @(negedge clk);
        checks++;
        if ({flush_ack, flush_err} !== 2'b10) begin
            errors++;
            $display("FAIL coll_refresh_ack got %b want 10", {flush_ack, flush_err});
        end
        @(posedge clk); #1;
        flush_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({rd_en, rd_id} !== {1'b1, 7'd49}) begin
            errors++;
            $display("FAIL coll_refresh_read got %h want %h", {rd_en, rd_id}, {1'b1, 7'd49});
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({restore_en, restore_lreg, restore_preg} !== {1'b1, f_lreg(49), f_ppreg(49)}) begin
            errors++;
            $display("FAIL coll_refresh_restore got %h want %h", {restore_en, restore_lreg, restore_preg},
                     {1'b1, f_lreg(49), f_ppreg(49)});
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({done, tail_wr_en, new_tail} !== {2'b11, 7'd49}) begin
            errors++;
            $display("FAIL coll_refresh_done got %h want %h", {done, tail_wr_en, new_tail}, {2'b11, 7'd49});
        end
    endtask

    initial begin
        test_reset();
        test_basic_walk();
        test_wrap_and_zero();
        test_illegal();
        test_pause_invalid();
        test_collisions();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
